bypass_hazard_ctrl: RTL and testbench
=====================================

Name: bypass_hazard_ctrl

Overview:
- Central hazard and forwarding controller for the 5-stage integer pipeline.
- Tracks destination-register metadata of in-flight instructions in shadow EX/MEM/WB slots.
- Produces the six registered bypass selects consumed by the ALU operand mux, plus the load-use stall and EX-bubble controls for fetch/decode.
- Sits beside the ID/EX pipeline register and advances in lock-step with it.

Parameters:
- REG_W, 5, register-specifier width.
- CNT_W, 32, width of the load-use stall performance counter.

Ports:
- clock  input  1  pipeline clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- id_valid  input  1  decode stage holds a real instruction.
- id_op  input  7  opcode of the decode-stage instruction (shared Opcodes encoding).
- id_rs1  input  REG_W  source 1 specifier.
- id_rs2  input  REG_W  source 2 specifier.
- id_rd  input  REG_W  destination specifier.
- mem_stall  input  1  data memory not ready; freezes the whole pipeline.
- flush  input  1  squash the decode-stage instruction (taken branch).
- bypassAfromMEM, bypassAfromALUinWB, bypassAfromLDinWB  output  1 each  registered operand-A selects for the instruction in EX.
- bypassBfromMEM, bypassBfromALUinWB, bypassBfromLDinWB  output  1 each  registered operand-B selects for the instruction in EX.
- stall_id  output  1  hold PC and IF/ID this cycle (combinational).
- bubble_ex  output  1  load a NOP into ID/EX on this advance (combinational).
- ex_valid, mem_valid, wb_valid  output  1 each  shadow-slot valid bits.
- load_use_count  output  CNT_W  number of load-use stall cycles taken.

Behaviour:
- Reset (async, reset_n=0): all slot valid/we/load bits 0, all bypass outputs 0, load_use_count 0.
- Slot contents: valid, rd, we, is_load.
  - we=1 for ALUopR, ALUopI, LW.
  - is_load=1 for LW only.
  - rd==0 forces we=0.
- Source usage:
  - rs1 used by ALUopR, ALUopI, LW, SW, BEQ.
  - rs2 used by ALUopR, SW, BEQ.
  - An unused or zero specifier never matches.
- advance = !mem_stall.
  - When mem_stall=1, all slots and bypass outputs hold; stall_id=1; bubble_ex=0; counter holds; flush is ignored (the source must hold it).
- Load-use hazard: lu = id_valid & EX.valid & EX.is_load & EX.we & (EX.rd matches a used rs1 or rs2).
- Priority per advancing cycle: flush > lu > normal.
  - flush: EX <= bubble; stall_id=0; bubble_ex=1.
  - lu: EX <= bubble; stall_id=1; bubble_ex=1; load_use_count += 1 (saturating at all-ones).
  - normal: EX <= ID slot (bubble if !id_valid); stall_id=0; bubble_ex=!id_valid.
  - In every advancing cycle, WB <= MEM and MEM <= EX.
- Bypass computation, per operand X in {A (rs1), B (rs2)}, evaluated against pre-advance slots and registered on advance:
  - If EX.valid & EX.we & !EX.is_load & EX.rd==rsX: XfromMEM=1.
  - Else if MEM.valid & MEM.we & MEM.rd==rsX: XfromLDinWB=MEM.is_load and XfromALUinWB=!MEM.is_load.
  - Else all three are 0.
  - At most one select per operand is 1.
  - When a bubble enters EX, all six selects are 0.
- Bypass latency: selects are valid the cycle the instruction occupies EX, i.e. one cycle after its decode advance.
- Distance-3 dependencies (producer in WB while consumer in ID) need no bypass; the register file is write-through.
- Load in MEM with consumer in EX cannot occur, because lu guarantees one bubble.
- B bypass is generated for SW and BEQ even though the ALU B input takes the immediate for SW; the forwarded value feeds store data.
- Back-to-back loads and same-rd writers: the youngest producer wins (EX slot checked before MEM).
- Reset asserted mid-stall clears everything immediately; the first cycle after release has no stall.

Decomposition:
- Shared package (the existing Opcodes include):
  - opcode constants ALUopR, ALUopI, LW, SW, BEQ;
  - a new slot_t struct {valid, rd, we, is_load};
  - helper functions writes_rd(op), uses_rs1(op), uses_rs2(op).
- One sub-module is natural: bypass_select_gen. It is purely combinational, instantiated twice (A, B), and maps (rs, EX slot, MEM slot) to three selects.

Test Plan:
- ADD x5 in EX, then ADD x6,x5,x5 decoded → next cycle bypassAfromMEM=1, bypassBfromMEM=1, others 0.
- LW x7 followed by ADD x8,x7,x1 → stall_id=1 and bubble_ex=1 for one cycle, load_use_count=1; next EX cycle bypassAfromLDinWB=1.
- ADD x3; NOP; SUB x4,x1,x3 → bypassBfromALUinWB=1; with x0 as destination instead, all selects 0.
- LW x9 with consumer, mem_stall=1 for 3 cycles → selects, slots and counter frozen; stall_id=1 throughout; after release exactly one load-use bubble, counter=1.
- flush and lu in the same cycle → bubble_ex=1, stall_id=0, counter unchanged.
- Assert reset_n=0 mid load-use stall → all outputs 0 asynchronously, ex/mem/wb_valid=0, count=0.

Source files
------------

// File: rtl/bypass_hazard_ctrl_pkg.sv
// Shared opcode constants, shadow-slot type and decode helpers for the
// bypass/hazard controller of the 5-stage integer pipeline.
package bypass_hazard_ctrl_pkg;

    localparam int unsigned SLOT_RD_W = 5;

    localparam logic [6:0] ALUopR = 7'b0110011;
    localparam logic [6:0] ALUopI = 7'b0010011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BEQ    = 7'b1100011;

    typedef struct packed {
        logic                 valid;
        logic [SLOT_RD_W-1:0] rd;
        logic                 we;
        logic                 is_load;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    function automatic logic writes_rd(input logic [6:0] op);
        logic r;
        case (op)
            ALUopR, ALUopI, LW: r = 1'b1;
            default:            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        logic r;
        case (op)
            ALUopR, ALUopI, LW, SW, BEQ: r = 1'b1;
            default:                     r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        logic r;
        case (op)
            ALUopR, SW, BEQ: r = 1'b1;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

    // x0 is hard-wired, so a write to it is never a forwarding source
    function automatic slot_t make_slot(input logic valid, input logic [6:0] op,
                                        input logic [SLOT_RD_W-1:0] rd);
        slot_t s;
        s.valid   = valid;
        s.rd      = rd;
        s.we      = valid & writes_rd(op) & (rd != {SLOT_RD_W{1'b0}});
        s.is_load = valid & (op == LW);
        return s;
    endfunction

endpackage

// File: rtl/bypass_hazard_ctrl_if.sv
// Decode-side inputs and forwarding/hazard outputs of the controller.
interface bypass_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [6:0]       id_op;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic [REG_W-1:0] id_rd;
    logic             mem_stall;
    logic             flush;

    logic             bypassAfromMEM;
    logic             bypassAfromALUinWB;
    logic             bypassAfromLDinWB;
    logic             bypassBfromMEM;
    logic             bypassBfromALUinWB;
    logic             bypassBfromLDinWB;
    logic             stall_id;
    logic             bubble_ex;
    logic             ex_valid;
    logic             mem_valid;
    logic             wb_valid;
    logic [CNT_W-1:0] load_use_count;

    modport master (
        output id_valid, id_op, id_rs1, id_rs2, id_rd, mem_stall, flush,
        input  bypassAfromMEM, bypassAfromALUinWB, bypassAfromLDinWB,
               bypassBfromMEM, bypassBfromALUinWB, bypassBfromLDinWB,
               stall_id, bubble_ex, ex_valid, mem_valid, wb_valid, load_use_count
    );

    modport slave (
        input  id_valid, id_op, id_rs1, id_rs2, id_rd, mem_stall, flush,
        output bypassAfromMEM, bypassAfromALUinWB, bypassAfromLDinWB,
               bypassBfromMEM, bypassBfromALUinWB, bypassBfromLDinWB,
               stall_id, bubble_ex, ex_valid, mem_valid, wb_valid, load_use_count
    );

endinterface

// File: rtl/bypass_select_gen.sv
// Combinational forwarding-source selection for one ALU operand; the EX
// slot is checked first so the youngest producer wins.
module bypass_select_gen
    import bypass_hazard_ctrl_pkg::*;
(
    input  logic [SLOT_RD_W-1:0] rs,
    input  logic                 rs_used,
    input  slot_t                ex_slot,
    input  slot_t                mem_slot,
    output logic                 from_mem,
    output logic                 from_alu_in_wb,
    output logic                 from_ld_in_wb
);

    logic rs_live_s;

    assign rs_live_s = rs_used & (rs != {SLOT_RD_W{1'b0}});

    // Pick at most one source; a load in EX is never a source (load-use stalls instead)
    always_comb begin
        from_mem       = 1'b0;
        from_alu_in_wb = 1'b0;
        from_ld_in_wb  = 1'b0;
        if (rs_live_s && ex_slot.valid && ex_slot.we && !ex_slot.is_load && (ex_slot.rd == rs)) begin
            from_mem = 1'b1;
        end else if (rs_live_s && mem_slot.valid && mem_slot.we && (mem_slot.rd == rs)) begin
            from_ld_in_wb  = mem_slot.is_load;
            from_alu_in_wb = !mem_slot.is_load;
        end else begin
            from_mem = 1'b0;
        end
    end

endmodule

// File: rtl/bypass_hazard_ctrl.sv
// Hazard/forwarding controller: shadows EX/MEM/WB destination metadata,
// registers operand bypass selects and raises load-use stalls.
module bypass_hazard_ctrl
    import bypass_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    bypass_hazard_ctrl_if.slave  bus
);

    slot_t            ex_q, ex_d;
    slot_t            mem_q, mem_d;
    logic             wb_valid_q, wb_valid_d;
    logic [2:0]       byp_a_q, byp_a_d;
    logic [2:0]       byp_b_q, byp_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [REG_W-1:0] rs1_s, rs2_s, rd_s;
    logic             rs1_used_s, rs2_used_s;
    logic             lu_s;
    logic             stall_id_s, bubble_ex_s;
    slot_t            id_slot_s;
    logic [2:0]       sel_a_s, sel_b_s;

    assign rs1_s      = bus.id_rs1;
    assign rs2_s      = bus.id_rs2;
    assign rd_s       = bus.id_rd;
    assign rs1_used_s = bus.id_valid & uses_rs1(bus.id_op);
    assign rs2_used_s = bus.id_valid & uses_rs2(bus.id_op);
    assign id_slot_s  = make_slot(bus.id_valid, bus.id_op, rd_s);

    assign lu_s = bus.id_valid & ex_q.valid & ex_q.is_load & ex_q.we &
                  ((rs1_used_s & (rs1_s != {REG_W{1'b0}}) & (ex_q.rd == rs1_s)) |
                   (rs2_used_s & (rs2_s != {REG_W{1'b0}}) & (ex_q.rd == rs2_s)));

    bypass_select_gen u_sel_a (
        .rs             (rs1_s),
        .rs_used        (rs1_used_s),
        .ex_slot        (ex_q),
        .mem_slot       (mem_q),
        .from_mem       (sel_a_s[2]),
        .from_alu_in_wb (sel_a_s[1]),
        .from_ld_in_wb  (sel_a_s[0])
    );

    bypass_select_gen u_sel_b (
        .rs             (rs2_s),
        .rs_used        (rs2_used_s),
        .ex_slot        (ex_q),
        .mem_slot       (mem_q),
        .from_mem       (sel_b_s[2]),
        .from_alu_in_wb (sel_b_s[1]),
        .from_ld_in_wb  (sel_b_s[0])
    );

    // Next-state for slots, selects and counter; flush outranks load-use
    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_valid_d  = wb_valid_q;
        byp_a_d     = byp_a_q;
        byp_b_d     = byp_b_q;
        cnt_d       = cnt_q;
        stall_id_s  = 1'b0;
        bubble_ex_s = 1'b0;
        if (bus.mem_stall) begin
            stall_id_s = 1'b1;
        end else begin
            wb_valid_d = mem_q.valid;
            mem_d      = ex_q;
            if (bus.flush) begin
                ex_d        = SLOT_BUBBLE;
                byp_a_d     = 3'b000;
                byp_b_d     = 3'b000;
                bubble_ex_s = 1'b1;
            end else if (lu_s) begin
                ex_d        = SLOT_BUBBLE;
                byp_a_d     = 3'b000;
                byp_b_d     = 3'b000;
                stall_id_s  = 1'b1;
                bubble_ex_s = 1'b1;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_d = cnt_q;
                end
            end else begin
                ex_d        = bus.id_valid ? id_slot_s : SLOT_BUBBLE;
                byp_a_d     = sel_a_s;
                byp_b_d     = sel_b_s;
                bubble_ex_s = !bus.id_valid;
            end
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_q       <= SLOT_BUBBLE;
            mem_q      <= SLOT_BUBBLE;
            wb_valid_q <= 1'b0;
            byp_a_q    <= 3'b000;
            byp_b_q    <= 3'b000;
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            ex_q       <= ex_d;
            mem_q      <= mem_d;
            wb_valid_q <= wb_valid_d;
            byp_a_q    <= byp_a_d;
            byp_b_q    <= byp_b_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.bypassAfromMEM     = byp_a_q[2];
    assign bus.bypassAfromALUinWB = byp_a_q[1];
    assign bus.bypassAfromLDinWB  = byp_a_q[0];
    assign bus.bypassBfromMEM     = byp_b_q[2];
    assign bus.bypassBfromALUinWB = byp_b_q[1];
    assign bus.bypassBfromLDinWB  = byp_b_q[0];
    assign bus.stall_id           = stall_id_s;
    assign bus.bubble_ex          = bubble_ex_s;
    assign bus.ex_valid           = ex_q.valid;
    assign bus.mem_valid          = mem_q.valid;
    assign bus.wb_valid           = wb_valid_q;
    assign bus.load_use_count     = cnt_q;

endmodule

// File: tb/tb_bypass_hazard_ctrl.sv
// Scoreboard bench: each driven cycle queues hand-computed expected outputs,
// a negedge monitor pops and compares them.
module tb_bypass_hazard_ctrl;
    import bypass_hazard_ctrl_pkg::*;

    typedef struct packed {
        logic [5:0]  sel;
        logic        stall;
        logic        bubble;
        logic [2:0]  vld;
        logic [31:0] cnt;
    } exp_t;

    logic clk;
    logic reset_n;
    exp_t  exp_q[$];
    string name_q[$];
    int    tests_run;
    int    failures;

    bypass_hazard_ctrl_if #(.REG_W(5), .CNT_W(32)) bus ();

    bypass_hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Monitor: compare DUT outputs against the oldest queued expectation
    always @(negedge clk) begin
        exp_t        e;
        string       n;
        logic [5:0]  a_sel;
        logic [2:0]  a_vld;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a_sel = {bus.bypassAfromMEM, bus.bypassAfromALUinWB, bus.bypassAfromLDinWB,
                     bus.bypassBfromMEM, bus.bypassBfromALUinWB, bus.bypassBfromLDinWB};
            a_vld = {bus.ex_valid, bus.mem_valid, bus.wb_valid};
            tests_run++;
            if (a_sel !== e.sel) begin
                failures++;
                $display("FAIL %s selects: got %b expected %b", n, a_sel, e.sel);
            end
            tests_run++;
            if ({bus.stall_id, bus.bubble_ex} !== {e.stall, e.bubble}) begin
                failures++;
                $display("FAIL %s stall/bubble: got %b%b expected %b%b", n,
                         bus.stall_id, bus.bubble_ex, e.stall, e.bubble);
            end
            tests_run++;
            if (a_vld !== e.vld) begin
                failures++;
                $display("FAIL %s valids: got %b expected %b", n, a_vld, e.vld);
            end
            tests_run++;
            if (bus.load_use_count !== e.cnt) begin
                failures++;
                $display("FAIL %s count: got %0d expected %0d", n, bus.load_use_count, e.cnt);
            end
        end
    end

    task automatic step(input logic rstn, input logic v, input logic [6:0] op,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic ms, input logic fl,
                        input logic [5:0] sel, input logic st, input logic bub,
                        input logic [2:0] vld, input logic [31:0] cnt, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n       = rstn;
        bus.id_valid  = v;
        bus.id_op     = op;
        bus.id_rs1    = rs1;
        bus.id_rs2    = rs2;
        bus.id_rd     = rd;
        bus.mem_stall = ms;
        bus.flush     = fl;
        e.sel = sel; e.stall = st; e.bubble = bub; e.vld = vld; e.cnt = cnt;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic nop(input logic [5:0] sel, input logic [2:0] vld,
                       input logic [31:0] cnt, input string name);
        step(1'b1, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, sel, 1'b0, 1'b1, vld, cnt, name);
    endtask

    initial begin
        tests_run = 0;
        failures  = 0;
        reset_n       = 1'b0;
        bus.id_valid  = 1'b0;
        bus.id_op     = 7'd0;
        bus.id_rs1    = 5'd0;
        bus.id_rs2    = 5'd0;
        bus.id_rd     = 5'd0;
        bus.mem_stall = 1'b0;
        bus.flush     = 1'b0;

        step(1'b0, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b1, 3'b000, 32'd0, "reset");

        // ADD x5 then dependent ADD x6,x5,x5: both operands from MEM, frozen under mem_stall
        step(1'b1, 1'b1, ALUopR, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 3'b000, 32'd0, "add_x5");
        step(1'b1, 1'b1, ALUopR, 5'd5, 5'd5, 5'd6, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 3'b100, 32'd0, "add_x6");
        step(1'b1, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 6'b100100, 1'b1, 1'b0, 3'b110, 32'd0, "fwd_mem_frozen");
        nop(6'b100100, 3'b110, 32'd0, "fwd_mem_ab");
        nop(6'b000000, 3'b011, 32'd0, "drain1a");
        nop(6'b000000, 3'b001, 32'd0, "drain1b");

        // LW x7 then ADD x8,x7,x1: one load-use bubble, then A from load in WB
        step(1'b1, 1'b1, LW, 5'd1, 5'd0, 5'd7, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 3'b000, 32'd0, "lw_x7");
        step(1'b1, 1'b1, ALUopR, 5'd7, 5'd1, 5'd8, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b1, 3'b100, 32'd0, "lu_stall");
        step(1'b1, 1'b1, ALUopR, 5'd7, 5'd1, 5'd8, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 3'b010, 32'd1, "lu_after");
        nop(6'b001000, 3'b101, 32'd1, "fwd_ld_a");
        nop(6'b000000, 3'b010, 32'd1, "drain2a");
        nop(6'b000000, 3'b001, 32'd1, "drain2b");

        // ADD x3; NOP; SUB x4,x1,x3: B from ALU result in WB
        step(1'b1, 1'b1, ALUopR, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 3'b000, 32'd1, "add_x3");
        nop(6'b000000, 3'b100, 32'd1, "gap3");
        step(1'b1, 1'b1, ALUopR, 5'd1, 5'd3, 5'd4, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 3'b010, 32'd1, "sub_x4");
        nop(6'b000010, 3'b101, 32'd1, "fwd_alu_wb_b");
        nop(6'b000000, 3'b010, 32'd1, "drain3a");
        nop(6'b000000, 3'b001, 32'd1, "drain3b");

        // Same with x0 as destination and source: no forwarding
        step(1'b1, 1'b1, ALUopR, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 3'b000, 32'd1, "add_x0");
        nop(6'b000000, 3'b100, 32'd1, "gap4");
        step(1'b1, 1'b1, ALUopR, 5'd1, 5'd0, 5'd4, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 3'b010, 32'd1, "sub_x0");
        nop(6'b000000, 3'b101, 32'd1, "x0_no_fwd");
        nop(6'b000000, 3'b010, 32'd1, "drain4a");
        nop(6'b000000, 3'b001, 32'd1, "drain4b");

        // LW x9 with consumer under 3 cycles of mem_stall, then exactly one bubble
        step(1'b1, 1'b1, LW, 5'd1, 5'd0, 5'd9, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 3'b000, 32'd1, "lw_x9");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, ALUopR, 5'd9, 5'd9, 5'd10, 1'b1, 1'b0, 6'b000000, 1'b1, 1'b0, 3'b100, 32'd1, "stall_hold");
        step(1'b1, 1'b1, ALUopR, 5'd9, 5'd9, 5'd10, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b1, 3'b100, 32'd1, "lu_release");
        step(1'b1, 1'b1, ALUopR, 5'd9, 5'd9, 5'd10, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 3'b010, 32'd2, "lu_once");
        nop(6'b001001, 3'b101, 32'd2, "fwd_ld_ab");
        nop(6'b000000, 3'b010, 32'd2, "drain5a");
        nop(6'b000000, 3'b001, 32'd2, "drain5b");

        // flush together with load-use: flush wins, counter untouched
        step(1'b1, 1'b1, LW, 5'd1, 5'd0, 5'd11, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 3'b000, 32'd2, "lw_x11");
        step(1'b1, 1'b1, ALUopR, 5'd11, 5'd1, 5'd12, 1'b0, 1'b1, 6'b000000, 1'b0, 1'b1, 3'b100, 32'd2, "flush_lu");
        nop(6'b000000, 3'b010, 32'd2, "drain6a");
        nop(6'b000000, 3'b001, 32'd2, "drain6b");
        nop(6'b000000, 3'b000, 32'd2, "flush_cnt");

        // Two writers of x13: youngest (EX) wins; SW feeds B but never writes
        step(1'b1, 1'b1, ALUopR, 5'd1, 5'd2, 5'd13, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 3'b000, 32'd2, "add_x13a");
        step(1'b1, 1'b1, ALUopR, 5'd2, 5'd2, 5'd13, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 3'b100, 32'd2, "add_x13b");
        step(1'b1, 1'b1, SW, 5'd13, 5'd13, 5'd5, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 3'b110, 32'd2, "sw_x13");
        step(1'b1, 1'b1, ALUopR, 5'd5, 5'd1, 5'd14, 1'b0, 1'b0, 6'b100100, 1'b0, 1'b0, 3'b111, 32'd2, "youngest_sw");
        nop(6'b000000, 3'b111, 32'd2, "sw_no_write");
        nop(6'b000000, 3'b011, 32'd2, "drain7a");
        nop(6'b000000, 3'b001, 32'd2, "drain7b");

        // Reset asserted during a held load-use stall
        step(1'b1, 1'b1, LW, 5'd1, 5'd0, 5'd15, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 3'b000, 32'd2, "lw_x15");
        step(1'b1, 1'b1, ALUopR, 5'd15, 5'd15, 5'd16, 1'b1, 1'b0, 6'b000000, 1'b1, 1'b0, 3'b100, 32'd2, "pre_rst_stall");
        step(1'b0, 1'b1, ALUopR, 5'd15, 5'd15, 5'd16, 1'b1, 1'b0, 6'b000000, 1'b1, 1'b0, 3'b000, 32'd0, "rst_mid_stall");
        step(1'b1, 1'b1, ALUopR, 5'd15, 5'd15, 5'd16, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 3'b000, 32'd0, "rst_release");
        nop(6'b000000, 3'b100, 32'd0, "post_rst");

        repeat (2) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            tests_run++;
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
